// File: rtl/bcp_axil_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite master.
// The read states exist only when BCP_ARB_READ_EN is defined.
package bcp_axil_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2
`ifdef BCP_ARB_READ_EN
    ,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
`endif
  } state_e;
endpackage

// File: rtl/bcp_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant register
// updated only when the grant is taken (advance).
module bcp_rr_arb2
  import bcp_axil_pkg::*;
(
  input  logic       aclk,
  input  logic       arst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      last_q <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/bcp_axil_master_arb.sv
// Shares one AXI4-Lite master port between two requesters; req_done is registered (3-cycle best-case write).
// Define BCP_ARB_READ_EN for the read path; without it reads complete with SLVERR and no AXI activity.
module bcp_axil_master_arb
  import bcp_axil_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [2*STRB_W-1:0] req_wstrb,
  output logic [1:0]          req_done,
  output logic [DATA_W-1:0]   req_rdata,
  output logic [1:0]          req_resp,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [STRB_W-1:0]   m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  state_e            state_q, state_d;
  logic [1:0]        grant, gnt_q, done_q, done_d, resp_q, resp_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done_q, w_done_q;
  logic              start, sel, aw_hs, w_hs, b_hs;

  // The requester whose done pulse is out still shows req_valid; keep it out for that cycle.
  bcp_rr_arb2 u_arb (
    .aclk   (aclk),
    .arst   (arst),
    .req    (req_valid & ~done_q),
    .advance(start),
    .grant  (grant)
  );

  assign start = (state_q == ST_IDLE) && (grant != 2'b00);
  assign sel   = grant[1];
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign b_hs  = m_bvalid && m_bready;

`ifdef BCP_ARB_READ_EN
  logic ar_hs, r_hs;
  assign ar_hs    = m_arvalid && m_arready;
  assign r_hs     = m_rvalid && m_rready;
  assign m_araddr = addr_q;
`else
  logic unused_rd;
  assign unused_rd = ^{m_arready, m_rvalid, m_rresp, m_rdata};
  assign m_araddr  = '0;
`endif

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef BCP_ARB_READ_EN
        if (start) state_d = req_we[sel] ? ST_WR : ST_RD_ADDR;
`else
        if (start) state_d = req_we[sel] ? ST_WR : ST_IDLE;
`endif
      end
      ST_WR:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = ST_IDLE;
`ifdef BCP_ARB_READ_EN
      ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs) state_d = ST_IDLE;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_awvalid = (state_q == ST_WR) && !aw_done_q;
    m_wvalid  = (state_q == ST_WR) && !w_done_q;
    m_bready  = (state_q == ST_WR_RESP);
`ifdef BCP_ARB_READ_EN
    m_arvalid = (state_q == ST_RD_ADDR);
    m_rready  = (state_q == ST_RD_DATA);
`else
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
`endif
  end

  always_comb begin
    done_d  = 2'b00;
    resp_d  = RESP_OKAY;
    rdata_d = '0;
    if (b_hs) begin
      done_d = gnt_q;
      resp_d = m_bresp;
    end
`ifdef BCP_ARB_READ_EN
    if (r_hs) begin
      done_d  = gnt_q;
      resp_d  = m_rresp;
      rdata_d = m_rdata;
    end
`else
    if (start && !req_we[sel]) begin
      done_d = grant;
      resp_d = RESP_SLVERR;
    end
`endif
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= '0;
      resp_q    <= '0;
      rdata_q   <= '0;
    end else begin
      done_q  <= done_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      if (start) begin
        gnt_q     <= grant;
        addr_q    <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        wdata_q   <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        wstrb_q   <= sel ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
    end
  end

  assign m_awaddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign req_done  = done_q;
  assign req_resp  = resp_q;
  assign req_rdata = rdata_q;

endmodule

// File: tb/tb_bcp_axil_master_arb.sv
// Directed bench for bcp_axil_master_arb: contention, single/staggered writes, read, reset abort.
module tb_bcp_axil_master_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          aclk = 1'b0;
  logic          arst = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [2*SW-1:0] req_wstrb = '0;
  logic [1:0]    req_done;
  logic [DW-1:0] req_rdata;
  logic [1:0]    req_resp;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic          m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic          m_arready = 1'b0, m_rvalid = 1'b0;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic [SW-1:0] m_wstrb;
  logic [1:0]    m_bresp = '0, m_rresp = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  int aw0, w0, b0, ar0;

  bcp_axil_master_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .arst(arst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 aclk = ~aclk;

  // Handshake counters sampled on the active edge
  always @(posedge aclk) begin
    if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
    if (m_wvalid && m_wready)   w_cnt  <= w_cnt + 1;
    if (m_bvalid && m_bready)   b_cnt  <= b_cnt + 1;
    if (m_arvalid)              ar_cnt <= ar_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {req_done, req_resp, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                        m_awprot, m_arprot}, 64'h0);
    chk({tag, "_addr"}, {m_awaddr, m_araddr}, 64'h0);
    chk({tag, "_data"}, {m_wdata, req_rdata}, 64'h0);
    chk({tag, "_strb"}, {60'h0, m_wstrb}, 64'h0);
  endtask

  initial begin
    // Reset state
    @(negedge aclk);
    chk_zero("reset");
    arst = 1'b0;
    @(negedge aclk);
    chk("idle_awvalid", m_awvalid, 1'b0);

    // Contention: both held, three writes each, expect 0,1,0,1,0,1
    req_valid = 2'b11; req_we = 2'b11;
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_wdata = {32'h0000_0020, 32'h0000_0010};
    req_wstrb = 8'hFF;
    m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b00;
    for (int i = 0; i < 6; i++) begin
      int r;
      logic [31:0] exp_d;
      r = i % 2;
      exp_d = (r == 1 ? 32'h20 : 32'h10) + 32'(i / 2);
      @(negedge aclk);
      chk("cont_awvalid", m_awvalid, 1'b1);
      chk("cont_awaddr", m_awaddr, (r == 1) ? 32'h200 : 32'h100);
      chk("cont_wdata", m_wdata, exp_d);
      @(negedge aclk);
      chk("cont_bready", m_bready, 1'b1);
      m_bvalid = 1'b1;
      @(negedge aclk);
      chk("cont_done", req_done, (r == 1) ? 2'b10 : 2'b01);
      chk("cont_resp", req_resp, 2'b00);
      m_bvalid = 1'b0;
      if (i / 2 < 2) req_wdata[r*32 +: 32] = exp_d + 32'h1;
      else           req_valid[r] = 1'b0;
    end
    @(negedge aclk);
    chk("cont_idle", {req_done, m_awvalid}, 3'b000);

    // Single write, zero-wait slave: done three cycles after req_valid
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr = 64'h0; req_wdata = {32'h0, 32'h5}; req_wstrb = 8'h0F;
    @(negedge aclk);
    chk("sw_valids", {m_awvalid, m_wvalid, m_bready}, 3'b110);
    chk("sw_awaddr", m_awaddr, 32'h0);
    chk("sw_wdata", m_wdata, 32'h5);
    chk("sw_wstrb", m_wstrb, 4'hF);
    @(negedge aclk);
    chk("sw_wresp", {m_awvalid, m_wvalid, m_bready, req_done}, 5'b00100);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge aclk);
    chk("sw_done", req_done, 2'b01);
    chk("sw_resp_rdata", {req_resp, req_rdata}, 34'h0);
    chk("sw_beats", {aw_cnt - aw0, w_cnt - w0, b_cnt - b0}, {32'd1, 32'd1, 32'd1});
    m_bvalid = 1'b0; req_valid = 2'b00;
    @(negedge aclk);
    chk("sw_done_pulse", req_done, 2'b00);

    // Staggered: AWREADY two cycles before WREADY, requester 1
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    req_valid = 2'b10; req_we = 2'b10;
    req_addr = {32'h8, 32'h0}; req_wdata = {32'hA5, 32'h0}; req_wstrb = 8'h30;
    m_awready = 1'b1; m_wready = 1'b0;
    @(negedge aclk);
    chk("stg_c1", {m_awvalid, m_wvalid}, 2'b11);
    @(negedge aclk);
    chk("stg_c2", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    chk("stg_payload", {m_awaddr, m_wdata}, {32'h8, 32'hA5});
    @(negedge aclk);
    chk("stg_c3", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    chk("stg_wstrb", m_wstrb, 4'h3);
    m_wready = 1'b1;
    @(negedge aclk);
    chk("stg_wresp", {m_awvalid, m_wvalid, m_bready}, 3'b001);
    m_bvalid = 1'b1; m_bresp = 2'b01;
    @(negedge aclk);
    chk("stg_done", {req_done, req_resp}, {2'b10, 2'b01});
    chk("stg_bready_low", m_bready, 1'b0);
    chk("stg_beats", {aw_cnt - aw0, w_cnt - w0, b_cnt - b0}, {32'd1, 32'd1, 32'd1});
    m_bvalid = 1'b0; m_bresp = 2'b00; req_valid = 2'b00;
    @(negedge aclk);

    // Read from requester 1
    ar0 = ar_cnt; aw0 = aw_cnt;
    req_valid = 2'b10; req_we = 2'b00;
    req_addr = {32'h4, 32'h0};
    m_arready = 1'b0;
`ifdef BCP_ARB_READ_EN
    @(negedge aclk);
    chk("rd_arvalid", {m_arvalid, m_araddr}, {1'b1, 32'h4});
    @(negedge aclk);
    chk("rd_ar_hold", {m_arvalid, m_araddr, m_rready}, {1'b1, 32'h4, 1'b0});
    m_arready = 1'b1;
    @(negedge aclk);
    chk("rd_data_phase", {m_arvalid, m_rready}, 2'b01);
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b10;
    @(negedge aclk);
    chk("rd_done", req_done, 2'b10);
    chk("rd_rdata", req_rdata, 32'hDEADBEEF);
    chk("rd_resp", req_resp, 2'b10);
    chk("rd_ar_cycles", ar_cnt - ar0, 32'd2);
    m_rvalid = 1'b0; req_valid = 2'b00;
    @(negedge aclk);
    chk("rd_idle", {req_done, m_rready}, 3'b000);
`else
    @(negedge aclk);
    chk("rd_done", req_done, 2'b10);
    chk("rd_slverr", {req_resp, req_rdata}, {2'b10, 32'h0});
    chk("rd_no_axi", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_araddr}, 36'h0);
    req_valid = 2'b00;
    @(negedge aclk);
    chk("rd_no_ar", {ar_cnt - ar0, aw_cnt - aw0}, 64'h0);
    chk("rd_pulse", req_done, 2'b00);
`endif

    // Reset while waiting for BVALID, request held across it
    req_valid = 2'b01; req_we = 2'b01;
    req_addr = {32'h0, 32'hC}; req_wdata = {32'h0, 32'h77}; req_wstrb = 8'h0F;
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge aclk);
    chk("rm_wr", m_awvalid, 1'b1);
    @(negedge aclk);
    chk("rm_wresp", m_bready, 1'b1);
    arst = 1'b1;
    #1;
    chk_zero("rm_assert");
    @(negedge aclk);
    chk_zero("rm_hold");
    arst = 1'b0;
    @(negedge aclk);
    chk("rm_reissue", {m_awvalid, m_wvalid, m_awaddr, m_wdata}, {2'b11, 32'hC, 32'h77});
    @(negedge aclk);
    chk("rm_wresp2", {m_bready, req_done}, 3'b100);
    m_bvalid = 1'b1;
    @(negedge aclk);
    chk("rm_done", {req_done, req_resp}, {2'b01, 2'b00});
    m_bvalid = 1'b0; req_valid = 2'b00;
    @(negedge aclk);
    chk("rm_end", req_done, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
